// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the CPU load/store path and a host port.
// Optional statistics counters are enabled with `define DMEM_ARB_STATS_EN.
module dmem_arbiter #(
   parameter int AW        = 8,
   parameter int DW        = 8,
   parameter int MAX_WAIT  = 4,
   parameter int MAX_BURST = 8
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          cpu_req,
   input  logic          cpu_wr,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdat,
   output logic [DW-1:0] cpu_rdat,
   output logic          cpu_stall,
   input  logic          host_req,
   input  logic          host_wr,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdat,
   output logic          host_gnt,
   output logic          host_ack,
   output logic [DW-1:0] host_rdat,
   output logic          mem_wr_en,
   output logic          mem_rd_en,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdat,
   input  logic [DW-1:0] mem_rdat,
`ifdef DMEM_ARB_STATS_EN
   output logic [15:0]   stall_cycles,
   output logic [15:0]   host_grants,
`endif
   output logic          arb_state
);

   // Host handshake: host_req is a level held with stable addr/data; an access
   // happens on every edge where host_gnt && host_req, and host_ack/host_rdat
   // report it one cycle later. The CPU simply replays while cpu_stall is high.
   localparam logic [0:0] CPU_OWN  = 1'b0;
   localparam logic [0:0] HOST_OWN = 1'b1;

   localparam logic [3:0] WAIT_MAX   = 4'(MAX_WAIT);
   localparam logic [7:0] BURST_MAX  = 8'(MAX_BURST);
   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

   logic [0:0] state;
   logic [3:0] wait_cnt;
   logic [7:0] burst_cnt;
   logic       host_acc;
   logic       go_host;
   logic       go_cpu;

   assign host_acc = (state == HOST_OWN) && host_req;
   assign go_host  = (state == CPU_OWN) && host_req && (!cpu_req || (wait_cnt == WAIT_MAX));
   // >= so a CPU request arriving after the burst count saturated still ends the grant.
   assign go_cpu   = (state == HOST_OWN) && (!host_req || (cpu_req && (burst_cnt >= BURST_LAST)));

   assign arb_state = state;

   always_comb begin
      host_gnt  = 1'b0;
      cpu_stall = 1'b0;
      cpu_rdat  = mem_rdat;
      mem_wr_en = cpu_req & cpu_wr;
      mem_rd_en = cpu_req & ~cpu_wr;
      mem_addr  = cpu_addr;
      mem_wdat  = cpu_wdat;
      if (state == HOST_OWN) begin
         host_gnt  = 1'b1;
         cpu_stall = cpu_req;
         cpu_rdat  = '0;
         mem_wr_en = host_acc & host_wr;
         mem_rd_en = host_acc & ~host_wr;
         mem_addr  = host_req ? host_addr : '0;
         mem_wdat  = host_req ? host_wdat : '0;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state <= CPU_OWN;
      end else if (go_host) begin
         state <= HOST_OWN;
      end else if (go_cpu) begin
         state <= CPU_OWN;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         wait_cnt  <= '0;
         burst_cnt <= '0;
      end else if (go_host) begin
         wait_cnt  <= '0;
         burst_cnt <= '0;
      end else if (state == CPU_OWN) begin
         if (!host_req) begin
            wait_cnt <= '0;
         end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 4'd1;
         end
      end else begin
         wait_cnt <= '0;
         if (host_acc && (burst_cnt != BURST_MAX)) begin
            burst_cnt <= burst_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         host_ack  <= 1'b0;
         host_rdat <= '0;
      end else begin
         host_ack <= host_acc;
         if (host_acc && !host_wr) begin
            host_rdat <= mem_rdat;
         end
      end
   end

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         stall_cycles <= '0;
         host_grants  <= '0;
      end else begin
         if (cpu_stall && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
         end
         if (go_host && (host_grants != 16'hFFFF)) begin
            host_grants <= host_grants + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: memory model, CPU/host drivers, expected-value queues
// fed from a reference memory image, and per-cycle ownership checks.
module tb_dmem_arbiter;
   localparam int AW        = 8;
   localparam int DW        = 8;
   localparam int MAX_WAIT  = 4;
   localparam int MAX_BURST = 8;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          cpu_req, cpu_wr;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdat, cpu_rdat;
   logic          cpu_stall;
   logic          host_req, host_wr;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdat;
   logic          host_gnt, host_ack;
   logic [DW-1:0] host_rdat;
   logic          mem_wr_en, mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdat, mem_rdat;
   logic          arb_state;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0]   stall_cycles, host_grants;
`endif

   // ---------------- clock ----------------
   always #5 Clk = ~Clk;

   dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
      .Clk(Clk), .Reset(Reset),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdat(cpu_wdat),
      .cpu_rdat(cpu_rdat), .cpu_stall(cpu_stall),
      .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdat(host_wdat),
      .host_gnt(host_gnt), .host_ack(host_ack), .host_rdat(host_rdat),
      .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_wdat(mem_wdat), .mem_rdat(mem_rdat),
`ifdef DMEM_ARB_STATS_EN
      .stall_cycles(stall_cycles), .host_grants(host_grants),
`endif
      .arb_state(arb_state)
   );

   // ---------------- DatMem model: combinational read, write at edge ----------------
   logic [DW-1:0] dmem [256];
   bit            written [256];

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return a ^ 8'h3C;
   endfunction

   assign mem_rdat = written[mem_addr] ? dmem[mem_addr] : pat(mem_addr);

   always @(posedge Clk) begin
      if (mem_wr_en) begin
         dmem[mem_addr]    <= mem_wdat;
         written[mem_addr] <= 1'b1;
      end
   end

   // ---------------- reference model and scoreboard ----------------
   logic [DW-1:0] ref_mem [256];
   logic [DW-1:0] last_host_rd;
   logic [DW-1:0] cpu_exp_q[$];
   logic [DW-1:0] host_exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s actual=%0h expected=none t=%0t", name, act, $time);
   endtask

   // Host ops complete in issue order, so the image at issue time gives the answer.
   task automatic host_push(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (wr) begin
         ref_mem[a] = d;
         host_exp_q.push_back(last_host_rd);
      end else begin
         last_host_rd = ref_mem[a];
         host_exp_q.push_back(ref_mem[a]);
      end
   endtask

   task automatic cpu_push(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (wr) ref_mem[a] = d;
      else    cpu_exp_q.push_back(ref_mem[a]);
   endtask

   // ---------------- drivers ----------------
   task automatic host_complete(input bit keep);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge Clk);
         if (host_gnt) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) fail("host_grant_timeout", {24'h0, host_addr});
      @(posedge Clk); #1;
      if (!keep) host_req = 1'b0;
   endtask

   task automatic host_access(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input bit keep);
      host_req  = 1'b1;
      host_wr   = wr;
      host_addr = a;
      host_wdat = d;
      host_push(wr, a, d);
      host_complete(keep);
   endtask

   task automatic cpu_access(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit done;
      cpu_req  = 1'b1;
      cpu_wr   = wr;
      cpu_addr = a;
      cpu_wdat = d;
      cpu_push(wr, a, d);
      done = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge Clk);
         if (!cpu_stall) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) fail("cpu_stall_timeout", {24'h0, a});
      @(posedge Clk); #1;
      cpu_req = 1'b0;
   endtask

   // ---------------- monitors ----------------
   always @(negedge Clk) begin
      if (Reset === 1'b1) begin
         if (cpu_req && !cpu_wr && !cpu_stall) begin
            if (cpu_exp_q.size() == 0) fail("cpu_rd_unexpected", {24'h0, cpu_rdat});
            else check("cpu_rdat", {24'h0, cpu_rdat}, {24'h0, cpu_exp_q.pop_front()});
         end
         if (host_ack) begin
            if (host_exp_q.size() == 0) fail("host_ack_unexpected", {24'h0, host_rdat});
            else check("host_rdat", {24'h0, host_rdat}, {24'h0, host_exp_q.pop_front()});
         end
      end
   end

   // Ownership routing: exactly one side drives the memory in any cycle.
   always @(negedge Clk) begin
      if (Reset === 1'b1) begin
         if (!host_gnt) begin
            check("route_cpu", {11'h0, mem_wr_en, mem_rd_en, cpu_stall, mem_addr, mem_wdat, cpu_rdat},
                  {11'h0, cpu_req & cpu_wr, cpu_req & ~cpu_wr, 1'b0, cpu_addr, cpu_wdat, mem_rdat});
         end else begin
            check("route_host_en", {21'h0, mem_wr_en, mem_rd_en, cpu_stall, cpu_rdat},
                  {21'h0, host_req & host_wr, host_req & ~host_wr, cpu_req, 8'h00});
            if (host_req) check("route_host_bus", {16'h0, mem_addr, mem_wdat},
                                {16'h0, host_addr, host_wdat});
         end
      end
   end

   int denied = 0;
   always @(negedge Clk) begin
      if (Reset !== 1'b1 || !host_req) begin
         denied = 0;
      end else if (!host_gnt) begin
         denied++;
      end else begin
         if (denied > 0) check("host_wait_bound", {31'h0, denied > MAX_WAIT + 1}, 32'h0);
         denied = 0;
      end
   end

   // ---------------- stimulus ----------------
   int  n, g, st, acks;
   bit  burst_done;
   bit  hkeep, hprev;
   int  cgap, hgap;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0] sc0, hg0;
`endif

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = pat(8'(i));
      last_host_rd = '0;

      // Reset with both sides requesting.
      Reset = 1'b0;
      cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h20; cpu_wdat = 8'h77;
      host_req = 1'b1; host_wr = 1'b0; host_addr = 8'h90; host_wdat = 8'h00;
      ref_mem[8'h20] = 8'h77;
      #2;
      check("rst_host_gnt", {31'h0, host_gnt}, 32'h0);
      check("rst_cpu_stall", {31'h0, cpu_stall}, 32'h0);
      check("rst_host_ack", {31'h0, host_ack}, 32'h0);
      check("rst_host_rdat", {24'h0, host_rdat}, 32'h0);
      check("rst_state", {31'h0, arb_state}, 32'h0);
      check("rst_pass", {14'h0, mem_wr_en, mem_rd_en, mem_addr, mem_wdat}, {14'h0, 2'b10, 8'h20, 8'h77});
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge Clk); #1;
         n++;
         if (host_gnt) break;
      end
      check("gnt_latency", n, MAX_WAIT + 1);
      host_req = 1'b0;
      cpu_req  = 1'b0;
      @(posedge Clk); #1;
      check("idle_grant_release", {31'h0, host_gnt}, 32'h0);

      // CPU idle, host write then CPU readback.
      host_req = 1'b1; host_wr = 1'b1; host_addr = 8'h10; host_wdat = 8'hA5;
      host_push(1'b1, 8'h10, 8'hA5);
      @(negedge Clk);
      check("wr_gnt_wait", {31'h0, host_gnt}, 32'h0);
      @(posedge Clk); #1;
      check("wr_gnt", {31'h0, host_gnt}, 32'h1);
      @(posedge Clk); #1;
      host_req = 1'b0;
      check("wr_ack", {31'h0, host_ack}, 32'h1);
      @(posedge Clk); #1;
      check("wr_ack_clear", {31'h0, host_ack}, 32'h0);
      cpu_access(1'b0, 8'h10, 8'h00);

      // Simultaneous requests with no accumulated wait: CPU goes first.
      host_req = 1'b1; host_wr = 1'b0; host_addr = 8'h85;
      host_push(1'b0, 8'h85, 8'h00);
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 8'h05;
      cpu_push(1'b0, 8'h05, 8'h00);
      @(negedge Clk);
      check("sim_mem_addr", {24'h0, mem_addr}, 32'h05);
      check("sim_cpu_stall", {31'h0, cpu_stall}, 32'h0);
      check("sim_host_gnt", {31'h0, host_gnt}, 32'h0);
      @(posedge Clk); #1;
      cpu_req = 1'b0;
      host_complete(1'b0);
      @(posedge Clk); #1;

      // Host burst of 12 reads against a waiting CPU store.
      cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h21; cpu_wdat = 8'h55;
      cpu_push(1'b1, 8'h21, 8'h55);
`ifdef DMEM_ARB_STATS_EN
      sc0 = stall_cycles;
      hg0 = host_grants;
`endif
      burst_done = 1'b0;
      fork
         begin
            for (int k = 0; k < 12; k++) host_access(1'b0, 8'(8'h40 + k), 8'h00, k < 11);
            burst_done = 1'b1;
         end
      join_none
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk);
         if (host_gnt) break;
      end
      g = 0; st = 0; acks = 0;
      for (int i = 0; i < 40; i++) begin
         if (!host_gnt) break;
         g++;
         if (cpu_stall) st++;
         if (host_ack) acks++;
         @(negedge Clk);
      end
      if (host_ack) acks++;
      check("burst_gnt_cycles", g, MAX_BURST);
      check("burst_stall_cycles", st, MAX_BURST);
      check("burst_acks", acks, MAX_BURST);
      check("burst_return_cpu", {30'h0, mem_wr_en, cpu_stall}, 32'h2);
`ifdef DMEM_ARB_STATS_EN
      check("stats_stall_cycles", {16'h0, 16'(stall_cycles - sc0)}, MAX_BURST);
      check("stats_host_grants", {16'h0, 16'(host_grants - hg0)}, 32'h1);
`endif
      for (int i = 0; i < 200; i++) begin
         @(posedge Clk); #2;
         if (burst_done) break;
      end
      check("burst_done", {31'h0, burst_done}, 32'h1);
      cpu_req = 1'b0;
      repeat (2) @(posedge Clk);
      #1;

      // Reset pulse during the third access of a host write burst.
      host_req = 1'b1; host_wr = 1'b1; host_addr = 8'h30; host_wdat = 8'h11;
      host_push(1'b1, 8'h30, 8'h11);
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      host_addr = 8'h31; host_wdat = 8'h22;
      host_push(1'b1, 8'h31, 8'h22);
      @(posedge Clk); #1;
      host_addr = 8'h32; host_wdat = 8'h33;
      @(negedge Clk); #1;
      Reset = 1'b0;
      #1;
      check("midrst_host_gnt", {31'h0, host_gnt}, 32'h0);
      check("midrst_host_ack", {31'h0, host_ack}, 32'h0);
      check("midrst_mem_wr_en", {31'h0, mem_wr_en}, 32'h0);
      host_req = 1'b0;
      last_host_rd = '0;
      @(posedge Clk); #1;
      Reset = 1'b1;
      @(posedge Clk); #1;
      cpu_access(1'b0, 8'h30, 8'h00);
      cpu_access(1'b0, 8'h31, 8'h00);
      cpu_access(1'b0, 8'h32, 8'h00);

      // Random traffic: CPU in the low half, host in the high half of memory.
      fork
         begin
            for (int k = 0; k < 40; k++) begin
               cgap = $urandom_range(0, 3);
               repeat (cgap) begin
                  @(posedge Clk); #1;
               end
               cpu_access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)), 8'($urandom));
            end
         end
         begin
            hprev = 1'b0;
            for (int k = 0; k < 40; k++) begin
               hkeep = ($urandom_range(0, 3) != 0) && (k < 39);
               if (!hprev) begin
                  hgap = $urandom_range(0, 4);
                  repeat (hgap) begin
                     @(posedge Clk); #1;
                  end
               end
               host_access(1'($urandom_range(0, 1)), 8'($urandom_range(128, 255)), 8'($urandom), hkeep);
               hprev = hkeep;
            end
         end
      join
      repeat (3) @(posedge Clk);
      #1;
      check("cpu_queue_empty", cpu_exp_q.size(), 0);
      check("host_queue_empty", host_exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
